// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl
//   Memory-side responder for the execute stage. Stores are posted into a
//   DEPTH-entry FIFO and acknowledged immediately; the FIFO drains to the
//   data-memory bus in order. Loads and fences wait until every posted
//   store has reached the bus, so memory ordering is preserved.
//
//   Optional build macro: STORE_FORWARD_EN
//     When defined, a load whose youngest matching FIFO entry is a full-word
//     store is answered directly from the FIFO in one cycle. When undefined,
//     no address comparators are built and loads always wait for the drain.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/fence/addr/wdata/wstrb   execute-stage request (held until rsp_ready)
//   rsp_ready, rsp_rdata  one-cycle completion pulse and load data
//   dmem_valid/addr/wdata/wstrb, dmem_ready, dmem_rdata   data-memory bus
//   empty, count          FIFO status
module store_buffer_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_fence,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wstrb,
  output logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             dmem_valid,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_wstrb,
  input  logic             dmem_ready,
  input  logic [31:0]      dmem_rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      rdata_q, rdata_d;

  // FIFO storage; no reset needed since count_q qualifies every entry.
  logic [31:0]      addr_mem  [DEPTH];
  logic [31:0]      wdata_mem [DEPTH];
  logic [3:0]       strb_mem  [DEPTH];

  logic             push, pop, is_empty, is_full, drain_valid;

  assign is_empty    = (count_q == '0);
  assign is_full     = (count_q == CNT_W'(DEPTH));
  // The head is offered to the bus whenever there is one, except while the
  // bus is owned by a load (which only happens with the FIFO empty anyway).
  assign drain_valid = !is_empty && (state_q != LOAD);
  assign pop         = drain_valid && dmem_ready;

`ifdef STORE_FORWARD_EN
  logic [DEPTH-1:0] fwd_hit;
  logic [PTR_W-1:0] fwd_slot [DEPTH];
  logic             fwd_full;
  logic [31:0]      fwd_data;

  // fwd_hit[gi] refers to the entry gi positions younger than the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
    assign fwd_slot[gi] = rd_ptr_q + PTR_W'(gi);
    assign fwd_hit[gi]  = (CNT_W'(gi) < count_q) &&
                          (addr_mem[fwd_slot[gi]][31:2] == req_addr[31:2]);
  end

  // Later (younger) hits override earlier ones, so the youngest match wins;
  // a partial youngest match suppresses forwarding even if an older full one exists.
  always_comb begin
    fwd_full = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (fwd_hit[k]) begin
        fwd_full = (strb_mem[fwd_slot[k]] == 4'hF);
        fwd_data = wdata_mem[fwd_slot[k]];
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_fence) begin
            if (is_empty) state_d = RESP;
          end else if (req_wstrb != 4'h0) begin
            // A same-cycle pop does not free a slot for this store.
            if (!is_full) begin
              push    = 1'b1;
              state_d = RESP;
            end
          end else begin
`ifdef STORE_FORWARD_EN
            if (fwd_full) begin
              rdata_d = fwd_data;
              state_d = RESP;
            end else if (is_empty) begin
              state_d = LOAD;
            end
`else
            if (is_empty) state_d = LOAD;
`endif
          end
        end
      end
      LOAD: begin
        if (dmem_ready) begin
          rdata_d = dmem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_valid = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    if (state_q == LOAD) begin
      dmem_valid = 1'b1;
      dmem_addr  = req_addr;
    end else if (drain_valid) begin
      dmem_valid = 1'b1;
      dmem_addr  = addr_mem[rd_ptr_q];
      dmem_wdata = wdata_mem[rd_ptr_q];
      dmem_wstrb = strb_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= req_addr;
      wdata_mem[wr_ptr_q] <= req_wdata;
      strb_mem[wr_ptr_q]  <= req_wstrb;
    end
  end

  assign rsp_ready = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign empty     = is_empty;
  assign count     = count_q;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
module tb_store_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_fence;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        dmem_valid;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        empty;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef STORE_FORWARD_EN
  localparam logic [3:0] SL_STRB = 4'h3;
`else
  localparam logic [3:0] SL_STRB = 4'hF;
`endif

  always #5 clk = ~clk;

  store_buffer_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_fence(req_fence), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .empty(empty), .count(count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    req_fence = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  // Presents a store in an IDLE cycle and advances one clock.
  task automatic store_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_fence = 1'b0;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    cyc();
    n_assert++; if (rsp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ready: got %b expected 0", rsp_ready); end
    n_assert++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_assert++; if (dmem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_valid: got %b expected 0", dmem_valid); end
    n_assert++; if (dmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_dmem_addr: got %h expected 0", dmem_addr); end
    n_assert++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_assert++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    cyc();
    rst = 1'b0;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(4 * i);
      store_cycle(a, 32'hA000 + 32'(i), 4'hF);
      n_assert++; if (rsp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ack%0d: got %b expected 1", i, rsp_ready); end
      idle_in();
      cyc();
    end
    n_assert++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_count_full: got %0d expected 4", count); end
    store_cycle(32'h110, 32'hA004, 4'hF);
    n_assert++; if (rsp_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_noack: got %b expected 0", rsp_ready); end
    dmem_ready = 1'b1;
    n_assert++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL b2b_head_addr: got %h expected 00000100", dmem_addr); end
    cyc();
    dmem_ready = 1'b0;
    n_assert++; if (rsp_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_no_credit: got %b expected 0", rsp_ready); end
    n_assert++; if (count !== 3'd3) begin n_fail++; $display("FAIL b2b_count_after_pop: got %0d expected 3", count); end
    cyc();
    n_assert++; if (rsp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_5th_ack: got %b expected 1", rsp_ready); end
    n_assert++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_count_refill: got %0d expected 4", count); end
    idle_in();
    cyc();
    dmem_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      a = 32'h100 + 32'(4 * i);
      n_assert++; if (dmem_valid !== 1'b1 || dmem_addr !== a || dmem_wdata !== 32'hA000 + 32'(i))
        begin n_fail++; $display("FAIL b2b_drain%0d: got v=%b a=%h d=%h expected v=1 a=%h", i, dmem_valid, dmem_addr, dmem_wdata, a); end
      cyc();
    end
    dmem_ready = 1'b0;
    n_assert++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b expected 1", empty); end
    $display("test_back_to_back done");
  endtask

  task automatic test_store_load();
    dmem_ready = 1'b0;
    store_cycle(32'h200, 32'hDEADBEEF, SL_STRB);
    n_assert++; if (rsp_ready !== 1'b1) begin n_fail++; $display("FAIL sl_store_ack: got %b expected 1", rsp_ready); end
    idle_in();
    cyc();
    req_valid = 1'b1;
    req_addr  = 32'h200;
    req_wstrb = 4'h0;
    cyc();
    n_assert++; if (rsp_ready !== 1'b0) begin n_fail++; $display("FAIL sl_load_waits: got %b expected 0", rsp_ready); end
    n_assert++; if (dmem_wstrb !== SL_STRB || dmem_wdata !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL sl_write_first: got strb=%h d=%h expected strb=%h d=deadbeef", dmem_wstrb, dmem_wdata, SL_STRB); end
    dmem_ready = 1'b1;
    cyc();
    dmem_ready = 1'b0;
    n_assert++; if (dmem_valid !== 1'b0) begin n_fail++; $display("FAIL sl_gap: got %b expected 0", dmem_valid); end
    cyc();
    n_assert++; if (dmem_valid !== 1'b1 || dmem_wstrb !== 4'h0 || dmem_addr !== 32'h200)
      begin n_fail++; $display("FAIL sl_read_issue: got v=%b strb=%h a=%h expected v=1 strb=0 a=00000200", dmem_valid, dmem_wstrb, dmem_addr); end
    cyc();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    cyc();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    n_assert++; if (rsp_ready !== 1'b1 || rsp_rdata !== 32'hCAFEF00D)
      begin n_fail++; $display("FAIL sl_load_rsp: got rdy=%b d=%h expected rdy=1 d=cafef00d", rsp_ready, rsp_rdata); end
    idle_in();
    cyc();
    n_assert++; if (rsp_ready !== 1'b0 || rsp_rdata !== 32'hCAFEF00D)
      begin n_fail++; $display("FAIL sl_hold: got rdy=%b d=%h expected rdy=0 d=cafef00d", rsp_ready, rsp_rdata); end
    $display("test_store_load done");
  endtask

  task automatic test_fence();
    dmem_ready = 1'b0;
    store_cycle(32'h500, 32'h1, 4'hF);
    idle_in();
    cyc();
    store_cycle(32'h504, 32'h2, 4'hF);
    idle_in();
    cyc();
    req_valid = 1'b1;
    req_fence = 1'b1;
    req_addr  = 32'hFFFF_FFF0;
    req_wstrb = 4'hF;
    cyc();
    n_assert++; if (rsp_ready !== 1'b0) begin n_fail++; $display("FAIL fence_wait0: got %b expected 0", rsp_ready); end
    dmem_ready = 1'b1;
    cyc();
    n_assert++; if (rsp_ready !== 1'b0 || count !== 3'd1)
      begin n_fail++; $display("FAIL fence_wait1: got rdy=%b cnt=%0d expected rdy=0 cnt=1", rsp_ready, count); end
    cyc();
    dmem_ready = 1'b0;
    n_assert++; if (rsp_ready !== 1'b0 || empty !== 1'b1)
      begin n_fail++; $display("FAIL fence_empty: got rdy=%b empty=%b expected rdy=0 empty=1", rsp_ready, empty); end
    cyc();
    n_assert++; if (rsp_ready !== 1'b1 || count !== 3'd0)
      begin n_fail++; $display("FAIL fence_ack: got rdy=%b cnt=%0d expected rdy=1 cnt=0", rsp_ready, count); end
    idle_in();
    cyc();
    $display("test_fence done");
  endtask

  task automatic test_simul();
    dmem_ready = 1'b0;
    store_cycle(32'h400, 32'h40, 4'hF);
    idle_in();
    cyc();
    store_cycle(32'h404, 32'h44, 4'hF);
    idle_in();
    cyc();
    n_assert++; if (count !== 3'd2) begin n_fail++; $display("FAIL sim_count_pre: got %0d expected 2", count); end
    req_valid  = 1'b1;
    req_addr   = 32'h408;
    req_wdata  = 32'h48;
    req_wstrb  = 4'hF;
    dmem_ready = 1'b1;
    cyc();
    dmem_ready = 1'b0;
    n_assert++; if (rsp_ready !== 1'b1 || count !== 3'd2 || dmem_addr !== 32'h404)
      begin n_fail++; $display("FAIL sim_push_pop: got rdy=%b cnt=%0d a=%h expected rdy=1 cnt=2 a=00000404", rsp_ready, count, dmem_addr); end
    idle_in();
    cyc();
    dmem_ready = 1'b1;
    cyc();
    n_assert++; if (dmem_addr !== 32'h408 || dmem_wdata !== 32'h48)
      begin n_fail++; $display("FAIL sim_order: got a=%h d=%h expected a=00000408 d=00000048", dmem_addr, dmem_wdata); end
    cyc();
    dmem_ready = 1'b0;
    n_assert++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_empty: got %b expected 1", empty); end
    $display("test_simul done");
  endtask

`ifdef STORE_FORWARD_EN
  task automatic test_forward();
    dmem_ready = 1'b0;
    store_cycle(32'h300, 32'h11111111, 4'hF);
    idle_in();
    cyc();
    store_cycle(32'h300, 32'h12345678, 4'hF);
    idle_in();
    cyc();
    store_cycle(32'h304, 32'h99999999, 4'hF);
    idle_in();
    cyc();
    req_valid = 1'b1;
    req_addr  = 32'h300;
    req_wstrb = 4'h0;
    cyc();
    n_assert++; if (rsp_ready !== 1'b1 || rsp_rdata !== 32'h12345678)
      begin n_fail++; $display("FAIL fwd_hit: got rdy=%b d=%h expected rdy=1 d=12345678", rsp_ready, rsp_rdata); end
    n_assert++; if (dmem_wstrb !== 4'hF || count !== 3'd3)
      begin n_fail++; $display("FAIL fwd_no_read: got strb=%h cnt=%0d expected strb=f cnt=3", dmem_wstrb, count); end
    idle_in();
    cyc();
    dmem_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    dmem_ready = 1'b0;
    n_assert++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwd_empty: got %b expected 1", empty); end
    $display("test_forward done");
  endtask
`endif

  task automatic test_reset_mid_drain();
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store_cycle(32'h600 + 32'(4 * i), 32'(i), 4'hF);
      idle_in();
      cyc();
    end
    n_assert++; if (dmem_valid !== 1'b1 || count !== 3'd3)
      begin n_fail++; $display("FAIL rmd_pre: got v=%b cnt=%0d expected v=1 cnt=3", dmem_valid, count); end
    #2;
    rst = 1'b1;
    #1;
    n_assert++; if (dmem_valid !== 1'b0) begin n_fail++; $display("FAIL rmd_valid: got %b expected 0", dmem_valid); end
    n_assert++; if (count !== 3'd0 || empty !== 1'b1 || rsp_ready !== 1'b0)
      begin n_fail++; $display("FAIL rmd_state: got cnt=%0d empty=%b rdy=%b expected 0/1/0", count, empty, rsp_ready); end
    cyc();
    rst = 1'b0;
    cyc();
    n_assert++; if (dmem_valid !== 1'b0 || count !== 3'd0)
      begin n_fail++; $display("FAIL rmd_after: got v=%b cnt=%0d expected v=0 cnt=0", dmem_valid, count); end
    $display("test_reset_mid_drain done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store_load();
    test_fence();
    test_simul();
`ifdef STORE_FORWARD_EN
    test_forward();
`endif
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
Memory-side responder for the execute stage's load/store/fence requests. It answers with rsp_ready/rsp_rdata, which the core treats as mem_ready/mem_rdata and stalls on while low.
- Stores are posted into a DEPTH-entry FIFO and drained to the data-memory bus in order.
- Loads and fences are ordered behind pending stores.
- Sits between the execute stage and the data memory / bus bridge.

Parameters:
DEPTH, 4, number of store entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the count output

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  core request present; held stable until the cycle rsp_ready=1
req_fence  in  1  fence request; req_addr/req_wdata/req_wstrb ignored
req_addr  in  32  byte address; word-aligned by core
req_wdata  in  32  store data, byte-lane aligned
req_wstrb  in  4  byte enables; 0 = load, non-zero = store
rsp_ready  out  1  one-cycle completion pulse to core
rsp_rdata  out  32  load data; valid when rsp_ready=1 for a load
dmem_valid  out  1  bus request
dmem_addr  out  32  bus address
dmem_wdata  out  32  bus write data
dmem_wstrb  out  4  bus byte enables; 0 = read
dmem_ready  in  1  bus completion; read data valid same cycle
dmem_rdata  in  32  bus read data
empty  out  1  FIFO empty
count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; FIFO pointers and count to 0.
  - rsp_ready=0, rsp_rdata=0, dmem_valid=0, dmem_addr/wdata/wstrb=0, empty=1, count=0.
  - Pending stores are discarded. An in-flight bus transaction is abandoned; dmem_valid drops immediately.
- FSM states: IDLE, LOAD, RESP.
- IDLE:
  - Store (req_valid, !req_fence, wstrb!=0) with count<DEPTH: enqueue {addr,wdata,wstrb} at the edge; next state RESP.
  - Store with count==DEPTH: stay in IDLE. A pop in the same cycle does not credit the enqueue; the enqueue occurs the following cycle.
  - Load (wstrb==0): wait in IDLE until empty=1 and no drain is in flight, then go to LOAD.
  - Fence: wait until empty=1 and no drain is in flight, then go to RESP.
- LOAD:
  - dmem_valid=1, dmem_addr=req_addr, dmem_wstrb=0.
  - On dmem_ready: register dmem_rdata into rsp_rdata; next state RESP.
- RESP:
  - rsp_ready=1 for exactly one cycle; req_* is ignored (still the old request); next state IDLE.
  - rsp_rdata holds its value until the next load completes.
- Latency:
  - Store, not full: 1 cycle (rsp_ready in the cycle after presentation).
  - Load, empty: 1 + bus latency + 1.
  - Fence, empty: 1.
- Drain:
  - Whenever the FIFO is non-empty and FSM!=LOAD, present the head on dmem_* with dmem_valid=1.
  - Hold the presented signals stable until dmem_ready; on dmem_ready, pop.
  - Drain and LOAD are mutually exclusive by construction; LOAD is entered only when empty.
- Simultaneous enqueue and pop with count<DEPTH: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. count is an explicit counter and distinguishes full from empty.
- req_valid=0 in IDLE: no action; draining continues.

Optional Feature:
STORE_FORWARD_EN:
- Defined:
  - A load in IDLE searches the FIFO for the youngest entry whose addr[31:2] equals req_addr[31:2].
  - If that entry has wstrb==4'hF: rsp_rdata <= entry wdata; next state RESP (1-cycle latency, no drain wait).
  - If the youngest match is partial (wstrb!=4'hF): wait for empty as in the base behaviour.
  - If there is no match and the FIFO is non-empty: wait for empty as in the base behaviour.
- Undefined: loads always wait for empty; no comparator logic is synthesised.

Test Plan:
- Reset mid-drain: 3 stores queued, rst=1 while dmem_valid=1 -> dmem_valid=0 immediately; count=0, empty=1, rsp_ready=0.
- Back-to-back stores with dmem_ready=0: stores to 0x100..0x10C -> 4 rsp_ready pulses, count=4. 5th store gets no rsp_ready. dmem_ready=1 for one cycle -> pop, and the 5th store is acked 2 cycles later.
- Store-then-load ordering: store 0xDEADBEEF to 0x200, then load 0x200, bus latency 2 -> load bus read issues only after the write handshake. rsp_rdata = bus return value; rsp_ready pulses once.
- Fence: 2 stores queued, fence presented -> rsp_ready only after both writes complete on dmem, 1 cycle after empty=1.
- Simultaneous enqueue/pop at count=2: store accepted while head pops -> count stays 2; FIFO order preserved on dmem_addr.
- STORE_FORWARD_EN: store 0x12345678 to 0x300 (wstrb F) held in FIFO with dmem_ready=0, then load 0x300 -> rsp_ready 1 cycle later, rsp_rdata=0x12345678, no dmem read. With wstrb=4'h3 -> load waits for drain.
